// File: rtl/matmul_sched_if.sv
// Control bus between the matmul sequencer and the operand/result RAMs and MAC lanes.
// The master side is the sequencer; the slave side is the datapath or a test harness.
interface matmul_sched_if #(
   parameter int CW = 16
) ();
   logic          go;
   logic [5:0]    a_addr;
   logic [5:0]    b_addr;
   logic          mac_en;
   logic          mac_load;
   logic          c_we;
   logic [2:0]    c_row;
   logic [2:0]    c_col;
   logic          busy;
   logic          done;
   logic [CW-1:0] cycles;

   modport master (
      input  go,
      output a_addr, b_addr, mac_en, mac_load, c_we, c_row, c_col, busy, done, cycles
   );

   modport slave (
      output go,
      input  a_addr, b_addr, mac_en, mac_load, c_we, c_row, c_col, busy, done, cycles
   );
endinterface

// File: rtl/matmul_sched.sv
// Sequencer for the 8x8 matrix multiply: walks 16 tiles (j outer, i inner), issues
// 8 k-steps of operand addresses, drives MAC enable/load and commits each tile to RAM C.
module matmul_sched #(
   parameter int N      = 8,
   parameter int LANES  = 4,
   parameter int RD_LAT = 1,
   parameter int CW     = 16
) (
   input logic            clk,
   input logic            rst,
   matmul_sched_if.master bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   localparam int         WW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [2:0] K_LAST = 3'(N - 1);
   localparam logic [2:0] J_LAST = 3'(N - 1);
   localparam logic [2:0] I_LAST = 3'(N - LANES);
   localparam logic [2:0] I_STEP = 3'(LANES);
   localparam logic [WW-1:0] W_LAST = WW'(RD_LAT - 1);

   logic [2:0]        state;
   logic [2:0]        j, i, k;
   logic [WW-1:0]     wcnt;
   logic [RD_LAT-1:0] en_sr, ld_sr, en_nxt, ld_nxt;
   logic [5:0]        a_hold, b_hold, a_cur, b_cur;
   logic [CW-1:0]     cyc;
   logic              issue, busy;

   assign issue = (state == S_ISSUE);
   assign busy  = issue || (state == S_WAIT) || (state == S_WRITE);
   assign a_cur = {k, i};
   assign b_cur = {j, k};

   // Delay line aligning MAC enable/load with operand data returning from the RAMs.
   if (RD_LAT == 1) begin : g_sr1
      assign en_nxt = issue;
      assign ld_nxt = issue && (k == '0);
   end else begin : g_srn
      assign en_nxt = {en_sr[RD_LAT-2:0], issue};
      assign ld_nxt = {ld_sr[RD_LAT-2:0], issue && (k == '0)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         j      <= '0;
         i      <= '0;
         k      <= '0;
         wcnt   <= '0;
         en_sr  <= '0;
         ld_sr  <= '0;
         a_hold <= '0;
         b_hold <= '0;
         cyc    <= '0;
      end else begin
         en_sr <= en_nxt;
         ld_sr <= ld_nxt;
         if (busy && (cyc != '1)) cyc <= cyc + 1'b1;
         case (state)
            S_IDLE: begin
               if (bus.go) begin
                  state <= S_ISSUE;
                  cyc   <= '0;
                  j     <= '0;
                  i     <= '0;
                  k     <= '0;
               end
            end
            S_ISSUE: begin
               a_hold <= a_cur;
               b_hold <= b_cur;
               k      <= k + 1'b1;
               if (k == K_LAST) begin
                  state <= S_WAIT;
                  wcnt  <= '0;
               end
            end
            S_WAIT: begin
               if (wcnt == W_LAST) state <= S_WRITE;
               else                wcnt  <= wcnt + 1'b1;
            end
            S_WRITE: begin
               k <= '0;
               if (i == I_LAST) begin
                  i <= '0;
                  j <= j + 1'b1;
               end else begin
                  i <= i + I_STEP;
               end
               if ((j == J_LAST) && (i == I_LAST)) state <= S_FIN;
               else                                state <= S_ISSUE;
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Addresses follow the live counters during ISSUE and hold the last issued value otherwise.
   assign bus.a_addr   = issue ? a_cur : a_hold;
   assign bus.b_addr   = issue ? b_cur : b_hold;
   assign bus.mac_en   = en_sr[RD_LAT-1];
   assign bus.mac_load = ld_sr[RD_LAT-1];
   assign bus.c_we     = (state == S_WRITE);
   assign bus.c_row    = i;
   assign bus.c_col    = j;
   assign bus.busy     = busy;
   assign bus.done     = (state == S_FIN);
   assign bus.cycles   = cyc;
endmodule

// File: tb/tb_matmul_sched.sv
// Bench for matmul_sched: RD_LAT=1 and RD_LAT=2 instances, a RAM/MAC model on the first,
// vector table for tile 0, and a queue scoreboard for every C write and done pulse.
module tb_matmul_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   matmul_sched_if #(.CW(16)) bus1 ();
   matmul_sched_if #(.CW(16)) bus2 ();

   matmul_sched #(.N(8), .LANES(4), .RD_LAT(1), .CW(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   matmul_sched #(.N(8), .LANES(4), .RD_LAT(2), .CW(16)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   typedef struct {
      int cyc;
      int row;
      int col;
   } ev_t;

   typedef struct {
      logic go;
      int   a;
      int   b;
      logic en;
      logic ld;
      logic we;
      logic busy;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   int   tick   = 0;
   ev_t  we_q[2][$];
   int   done_q[2][$];
   int   ev_cnt[2];
   int   amem[64], bmem[64], cmem[64];
   int   a_q[4], b_q, lane[4];

   always @(posedge clk) tick <= tick + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic push_run(input int d, input int t0, input int lat);
      for (int g = 0; g < 16; g++)
         we_q[d].push_back('{cyc: t0 + (g + 1) * (9 + lat), row: (g % 2) * 4, col: g / 2});
      done_q[d].push_back(t0 + 16 * (9 + lat) + 1);
   endtask

   // Observed cycle number is tick+1: outputs after posedge t belong to cycle t+1.
   task automatic mon(input int d, input logic we, input logic [2:0] row, input logic [2:0] col,
                      input logic dn, input logic [15:0] cyc, input logic bsy, input int lat);
      ev_t e;
      int  t;
      int  now;
      now = tick + 1;
      if (we) begin
         ev_cnt[d]++;
         if (we_q[d].size() == 0) chk($sformatf("we_unexpected_d%0d", d), now, -1);
         else begin
            e = we_q[d].pop_front();
            chk($sformatf("we_cycle_d%0d", d), now, e.cyc);
            chk($sformatf("we_row_d%0d", d), row, e.row);
            chk($sformatf("we_col_d%0d", d), col, e.col);
         end
      end
      if (dn) begin
         ev_cnt[d]++;
         if (done_q[d].size() == 0) chk($sformatf("done_unexpected_d%0d", d), now, -1);
         else begin
            t = done_q[d].pop_front();
            chk($sformatf("done_cycle_d%0d", d), now, t);
            chk($sformatf("done_cycles_d%0d", d), cyc, 16 * (9 + lat));
            chk($sformatf("done_busy_d%0d", d), bsy, 0);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, bus1.c_we, bus1.c_row, bus1.c_col, bus1.done, bus1.cycles, bus1.busy, 1);
      mon(1, bus2.c_we, bus2.c_row, bus2.c_col, bus2.done, bus2.cycles, bus2.busy, 2);
   end

   // RAM A/B with one cycle read latency, four MAC lanes and RAM C around dut1.
   always @(posedge clk) begin
      for (int r = 0; r < 4; r++) begin
         a_q[r] <= amem[int'(bus1.a_addr) + r];
         if (bus1.mac_en) lane[r] <= (bus1.mac_load ? 0 : lane[r]) + a_q[r] * b_q;
         if (bus1.c_we) cmem[(int'(bus1.c_row) + r) * 8 + int'(bus1.c_col)] <= lane[r];
      end
      b_q <= bmem[int'(bus1.b_addr)];
   end

   task automatic wait_tick(input int t);
      while (tick < t) @(negedge clk);
   endtask

   task automatic pulse_go(input int d, input bit accept, output int t0);
      t0 = tick + 1;
      if (d == 0) bus1.go = 1'b1;
      else        bus2.go = 1'b1;
      if (accept) push_run(d, t0, d + 1);
      @(negedge clk);
      bus1.go = 1'b0;
      bus2.go = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, {bus1.a_addr, bus1.b_addr}, 0);
      chk({tag, "_ctl"}, {bus1.mac_en, bus1.mac_load, bus1.c_we, bus1.c_row, bus1.c_col,
                          bus1.busy, bus1.done}, 0);
      chk({tag, "_cycles"}, bus1.cycles, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got tick %0d want finish", tick);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tab[13];
      int   t0, t1, snap;

      tab[0]  = '{1'b1,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      tab[1]  = '{1'b0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
      tab[2]  = '{1'b0,  8, 1, 1'b1, 1'b1, 1'b0, 1'b1};
      tab[3]  = '{1'b0, 16, 2, 1'b1, 1'b0, 1'b0, 1'b1};
      tab[4]  = '{1'b0, 24, 3, 1'b1, 1'b0, 1'b0, 1'b1};
      tab[5]  = '{1'b0, 32, 4, 1'b1, 1'b0, 1'b0, 1'b1};
      tab[6]  = '{1'b0, 40, 5, 1'b1, 1'b0, 1'b0, 1'b1};
      tab[7]  = '{1'b0, 48, 6, 1'b1, 1'b0, 1'b0, 1'b1};
      tab[8]  = '{1'b0, 56, 7, 1'b1, 1'b0, 1'b0, 1'b1};
      tab[9]  = '{1'b0, 56, 7, 1'b1, 1'b0, 1'b0, 1'b1};
      tab[10] = '{1'b0, 56, 7, 1'b0, 1'b0, 1'b1, 1'b1};
      tab[11] = '{1'b0,  4, 0, 1'b0, 1'b0, 1'b0, 1'b1};
      tab[12] = '{1'b0, 12, 1, 1'b1, 1'b1, 1'b0, 1'b1};

      bus1.go = 1'b0;
      bus2.go = 1'b0;
      for (int n = 0; n < 64; n++) begin
         amem[n] = ((n / 8) == (n % 8)) ? 1 : 0;
         bmem[n] = n - 32;
         cmem[n] = 0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_zero("reset");
      chk("reset_busy2", {bus2.busy, bus2.done, bus2.mac_en}, 0);

      // Identity A: tile 0 trace from the table, then the full run via the scoreboard.
      t0 = 0;
      for (int e = 0; e < 13; e++) begin
         chk($sformatf("vec%0d", e),
             {bus1.a_addr, bus1.b_addr, bus1.mac_en, bus1.mac_load, bus1.c_we, bus1.busy},
             {6'(tab[e].a), 6'(tab[e].b), tab[e].en, tab[e].ld, tab[e].we, tab[e].busy});
         bus1.go = tab[e].go;
         if (tab[e].go) begin
            t0 = tick + 1;
            push_run(0, t0, 1);
         end
         @(negedge clk);
      end
      wait_tick(t0 + 163);
      chk("run1_queue_empty", we_q[0].size() + done_q[0].size(), 0);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            chk($sformatf("c_ident_r%0d_c%0d", r, c), cmem[r * 8 + c], c * 8 + r - 32);

      // All -128 operands; a stray go mid-run, then go right after done restarts.
      for (int n = 0; n < 64; n++) begin
         amem[n] = -128;
         bmem[n] = -128;
      end
      pulse_go(0, 1'b1, t0);
      wait_tick(t0 + 49);
      pulse_go(0, 1'b0, t1);
      wait_tick(t0 + 161);
      pulse_go(0, 1'b1, t1);
      chk("restart_at", t1, t0 + 162);
      chk("cycles_cleared", bus1.cycles, 0);
      chk("restart_busy", bus1.busy, 1);
      wait_tick(t1 + 163);
      chk("run3_queue_empty", we_q[0].size() + done_q[0].size(), 0);
      for (int n = 0; n < 64; n++)
         chk($sformatf("c_neg_%0d", n), cmem[n], 131072);
      chk("cycles_hold", bus1.cycles, 160);

      // Reset mid-run abandons everything.
      pulse_go(0, 1'b1, t0);
      wait_tick(t0 + 34);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("midrst");
      we_q[0].delete();
      done_q[0].delete();
      rst  = 1'b0;
      snap = ev_cnt[0];
      repeat (40) @(negedge clk);
      chk("no_events_after_rst", ev_cnt[0] - snap, 0);
      chk("idle_after_rst", {bus1.busy, bus1.done, bus1.c_we}, 0);

      // RD_LAT=2 instance: enable window and scoreboarded schedule.
      pulse_go(1, 1'b1, t0);
      for (int e = 1; e <= 12; e++) begin
         chk($sformatf("lat2_en_%0d", e), bus2.mac_en, (e >= 3 && e <= 10) ? 1 : 0);
         chk($sformatf("lat2_ld_%0d", e), bus2.mac_load, (e == 3) ? 1 : 0);
         @(negedge clk);
      end
      wait_tick(t0 + 180);
      chk("lat2_queue_empty", we_q[1].size() + done_q[1].size(), 0);
      chk("lat2_cycles", bus2.cycles, 176);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
